// File: rtl/line_receiver_if.sv
// Handshake and read-port bundle between the UART side, line_receiver and the command decoders.
// master: the side that feeds bytes and consumes lines; slave: line_receiver itself.
interface line_receiver_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        rx_data;
    logic              new_rx_data;
    logic              line_valid;
    logic [ADDR_W:0]   line_len;
    logic              overflow;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              line_ack;
    logic [7:0]        tx_data;
    logic              new_tx_data;
    logic              tx_busy;

    modport master (
        output rx_data, new_rx_data, rd_addr, line_ack, tx_busy,
        input  line_valid, line_len, overflow, rd_data, tx_data, new_tx_data
    );

    modport slave (
        input  rx_data, new_rx_data, rd_addr, line_ack, tx_busy,
        output line_valid, line_len, overflow, rd_data, tx_data, new_tx_data
    );
endinterface

// File: rtl/line_receiver.sv
// Line buffer for UART input with backspace editing and a registered read port for command logic.
// Optional character echo on the UART transmit handshake is built when LINE_RECEIVER_ECHO_EN is defined.
module line_receiver #(
    parameter int MAX_LEN = 16,
    parameter int ADDR_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    line_receiver_if.slave bus
);
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_LEN);

    typedef enum logic {RECV, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [ADDR_W:0] count_reg, count_next;
    logic [ADDR_W:0] len_reg, len_next;
    logic            overflow_reg, overflow_next;
    logic            wr_en;
    logic            is_term, is_erase;
    logic            echo_req, echo_lf;
    logic [7:0]      echo_byte;

    // Sized to the full address space so any rd_addr maps to a real entry.
    logic [7:0] buffer [2**ADDR_W];
    logic [7:0] rd_data_reg;

    assign is_term  = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    assign is_erase = (bus.rx_data == 8'h08) || (bus.rx_data == 8'h7F);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RECV;
            count_reg    <= '0;
            len_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            len_reg      <= len_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        len_next      = len_reg;
        overflow_next = overflow_reg;
        wr_en         = 1'b0;
        echo_req      = 1'b0;
        echo_lf       = 1'b0;
        echo_byte     = 8'h00;
        case (state_reg)
            RECV: begin
                if (bus.new_rx_data) begin
                    if (is_term) begin
                        // Empty terminators are ignored so CR LF produces a single line.
                        if (count_reg != '0) begin
                            len_next   = count_reg;
                            state_next = HOLD;
                            echo_req   = 1'b1;
                            echo_lf    = 1'b1;
                            echo_byte  = 8'h0D;
                        end
                    end else if (is_erase) begin
                        if (count_reg != '0) begin
                            count_next = count_reg - 1'b1;
                            echo_req   = 1'b1;
                            echo_byte  = 8'h08;
                        end
                    end else if (count_reg < MAX_CNT) begin
                        wr_en      = 1'b1;
                        count_next = count_reg + 1'b1;
                        echo_req   = 1'b1;
                        echo_byte  = bus.rx_data;
                    end else begin
                        overflow_next = 1'b1;
                        echo_req      = 1'b1;
                        echo_byte     = 8'h07;
                    end
                end
            end
            HOLD: begin
                if (bus.line_ack) begin
                    state_next    = RECV;
                    count_next    = '0;
                    len_next      = '0;
                    overflow_next = 1'b0;
                end
            end
            default: state_next = RECV;
        endcase
    end

    // Buffer and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[count_reg[ADDR_W-1:0]] <= bus.rx_data;
        end
        rd_data_reg <= buffer[bus.rd_addr];
    end

    assign bus.line_valid = (state_reg == HOLD);
    assign bus.line_len   = len_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.rd_data    = rd_data_reg;

`ifdef LINE_RECEIVER_ECHO_EN
    logic [7:0] q_data_reg [2];
    logic [7:0] q_data_next [2];
    logic [1:0] q_count_reg, q_count_next;
    logic       pop;

    assign pop = (q_count_reg != 2'd0) && !bus.tx_busy;

    // Pop first, then append; requests that find no free slot are discarded.
    always_comb begin
        q_data_next[0] = q_data_reg[0];
        q_data_next[1] = q_data_reg[1];
        q_count_next   = q_count_reg;
        if (pop) begin
            q_data_next[0] = q_data_reg[1];
            q_count_next   = q_count_reg - 2'd1;
        end
        if (echo_req && (q_count_next != 2'd2)) begin
            q_data_next[q_count_next[0]] = echo_byte;
            q_count_next                 = q_count_next + 2'd1;
        end
        if (echo_lf && (q_count_next != 2'd2)) begin
            q_data_next[q_count_next[0]] = 8'h0A;
            q_count_next                 = q_count_next + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_data_reg[0] <= 8'h00;
            q_data_reg[1] <= 8'h00;
            q_count_reg   <= 2'd0;
        end else begin
            q_data_reg[0] <= q_data_next[0];
            q_data_reg[1] <= q_data_next[1];
            q_count_reg   <= q_count_next;
        end
    end

    assign bus.new_tx_data = pop;
    assign bus.tx_data     = q_data_reg[0];
`else
    logic unused_echo;
    assign unused_echo     = ^{bus.tx_busy, echo_req, echo_lf, echo_byte};
    assign bus.new_tx_data = 1'b0;
    assign bus.tx_data     = 8'h00;
`endif
endmodule
